// File: rtl/mem_access_unit_pkg.sv
// Shared types and decode helpers for the memory-access pipeline stage.
// Op codes match the dataCacheControl encoding carried down from the ALU stage.
package mem_access_unit_pkg;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LH   = 4'd2,
    MEM_LW   = 4'd3,
    MEM_LBU  = 4'd4,
    MEM_LHU  = 4'd5,
    MEM_SB   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SW   = 4'd8
  } mem_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Unused codes collapse to MEM_NONE so they behave as ordinary ALU ops.
  function automatic mem_op_e decode_op(input logic [3:0] code);
    case (code)
      4'd1:    return MEM_LB;
      4'd2:    return MEM_LH;
      4'd3:    return MEM_LW;
      4'd4:    return MEM_LBU;
      4'd5:    return MEM_LHU;
      4'd6:    return MEM_SB;
      4'd7:    return MEM_SH;
      4'd8:    return MEM_SW;
      default: return MEM_NONE;
    endcase
  endfunction

  function automatic logic is_store(input mem_op_e op);
    return op inside {MEM_SB, MEM_SH, MEM_SW};
  endfunction

  function automatic logic is_aligned(input mem_op_e op, input logic [1:0] lane);
    case (op)
      MEM_LH, MEM_LHU, MEM_SH: return ~lane[0];
      MEM_LW, MEM_SW:          return lane == 2'b00;
      default:                 return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Selects the addressed byte/halfword of a read word and sign- or zero-extends it.
module mem_load_align
  import mem_access_unit_pkg::*;
(
  input  mem_op_e     op,
  input  logic [1:0]  lane,
  input  logic [31:0] mem_rdata,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (lane)
      2'd0:    byte_sel = mem_rdata[7:0];
      2'd1:    byte_sel = mem_rdata[15:8];
      2'd2:    byte_sel = mem_rdata[23:16];
      default: byte_sel = mem_rdata[31:24];
    endcase
    half_sel = lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    case (op)
      MEM_LB:  load_data = {{24{byte_sel[7]}}, byte_sel};
      MEM_LBU: load_data = {24'd0, byte_sel};
      MEM_LH:  load_data = {{16{half_sel[15]}}, half_sel};
      MEM_LHU: load_data = {16'd0, half_sel};
      default: load_data = mem_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage: runs loads/stores over a req/ack port, stalls upstream while busy,
// and registers the write-back bundle for the WB stage.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inValid,
  input  logic [31:0] aluResult,
  input  logic [31:0] storeData,
  input  logic [3:0]  dataCacheControl,
  input  logic        writeEnableIn,
  input  logic [4:0]  writeBackAddrIn,
  output logic        stall,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [31:0] memWdata,
  output logic [3:0]  memByteEn,
  input  logic        memAck,
  input  logic [31:0] memRdata,
  output logic        validOut,
  output logic        writeEnableOut,
  output logic [4:0]  writeBackAddrOut,
  output logic [31:0] writeBackData,
  output logic        misaligned,
  output logic        busError
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // The timeout fires in the BUSY cycle that would bring the count up to TIMEOUT_CYCLES.
  localparam logic [CW-1:0] CNT_LIMIT = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  mem_op_e         op_q, op_d;
  logic [1:0]      lane_q, lane_d;
  logic [4:0]      rd_q, rd_d;
  logic            rd_we_q, rd_we_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [31:0]     mem_addr_q, mem_addr_d;
  logic [31:0]     mem_wdata_q, mem_wdata_d;
  logic [3:0]      mem_be_q, mem_be_d;
  logic            valid_q, valid_d;
  logic            wen_q, wen_d;
  logic [4:0]      wb_addr_q, wb_addr_d;
  logic [31:0]     wb_data_q, wb_data_d;
  logic            misaligned_q, misaligned_d;
  logic            bus_error_q, bus_error_d;
  logic            stall_c;
  logic            timeout_hit;
  mem_op_e         op_in;
  logic [1:0]      lane_in;
  logic [31:0]     load_data;

  mem_load_align u_load_align (
    .op        (op_q),
    .lane      (lane_q),
    .mem_rdata (memRdata),
    .load_data (load_data)
  );

  assign op_in       = decode_op(dataCacheControl);
  assign lane_in     = aluResult[1:0];
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LIMIT);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    lane_d       = lane_q;
    rd_d         = rd_q;
    rd_we_d      = rd_we_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_be_d     = mem_be_q;
    valid_d      = 1'b0;
    wen_d        = 1'b0;
    wb_addr_d    = wb_addr_q;
    wb_data_d    = wb_data_q;
    misaligned_d = 1'b0;
    bus_error_d  = 1'b0;
    stall_c      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        wb_addr_d = writeBackAddrIn;
        wb_data_d = aluResult;
        if (inValid && op_in != MEM_NONE) begin
          if (is_aligned(op_in, lane_in)) begin
            stall_c     = 1'b1;
            state_d     = ST_BUSY;
            cnt_d       = '0;
            op_d        = op_in;
            lane_d      = lane_in;
            rd_d        = writeBackAddrIn;
            rd_we_d     = writeEnableIn;
            mem_req_d   = 1'b1;
            mem_we_d    = is_store(op_in);
            mem_addr_d  = {aluResult[31:2], 2'b00};
            case (op_in)
              MEM_SB: begin
                mem_wdata_d = {4{storeData[7:0]}};
                mem_be_d    = 4'b0001 << lane_in;
              end
              MEM_SH: begin
                mem_wdata_d = {2{storeData[15:0]}};
                mem_be_d    = 4'b0011 << lane_in;
              end
              MEM_SW: begin
                mem_wdata_d = storeData;
                mem_be_d    = 4'b1111;
              end
              default: begin
                mem_wdata_d = '0;
                mem_be_d    = 4'b1111;
              end
            endcase
          end else begin
            misaligned_d = 1'b1;
            valid_d      = 1'b1;
          end
        end else begin
          valid_d = inValid;
          wen_d   = inValid & writeEnableIn;
        end
      end

      ST_BUSY: begin
        stall_c = ~memAck;
        if (memAck) begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          valid_d   = 1'b1;
          wen_d     = rd_we_q & ~is_store(op_q);
          wb_addr_d = rd_q;
          wb_data_d = load_data;
        end else if (timeout_hit) begin
          stall_c     = 1'b0;
          state_d     = ST_IDLE;
          cnt_d       = cnt_q + CW'(1);
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          valid_d     = 1'b1;
          bus_error_d = 1'b1;
          wb_addr_d   = rd_q;
          wb_data_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      op_q         <= MEM_NONE;
      lane_q       <= '0;
      rd_q         <= '0;
      rd_we_q      <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_be_q     <= '0;
      valid_q      <= 1'b0;
      wen_q        <= 1'b0;
      wb_addr_q    <= '0;
      wb_data_q    <= '0;
      misaligned_q <= 1'b0;
      bus_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      lane_q       <= lane_d;
      rd_q         <= rd_d;
      rd_we_q      <= rd_we_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_be_q     <= mem_be_d;
      valid_q      <= valid_d;
      wen_q        <= wen_d;
      wb_addr_q    <= wb_addr_d;
      wb_data_q    <= wb_data_d;
      misaligned_q <= misaligned_d;
      bus_error_q  <= bus_error_d;
    end
  end

  assign stall            = stall_c & ~rst;
  assign memReq           = mem_req_q;
  assign memWe            = mem_we_q;
  assign memAddr          = mem_addr_q;
  assign memWdata         = mem_wdata_q;
  assign memByteEn        = mem_be_q;
  assign validOut         = valid_q;
  assign writeEnableOut   = wen_q;
  assign writeBackAddrOut = wb_addr_q;
  assign writeBackData    = wb_data_q;
  assign misaligned       = misaligned_q;
  assign busError         = bus_error_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: pass-through, loads, stores, misalignment,
// timeout abort and mid-transaction reset, with hand-computed expectations.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        inValid;
  logic [31:0] aluResult;
  logic [31:0] storeData;
  logic [3:0]  dataCacheControl;
  logic        writeEnableIn;
  logic [4:0]  writeBackAddrIn;
  logic        stall;
  logic        memReq;
  logic        memWe;
  logic [31:0] memAddr;
  logic [31:0] memWdata;
  logic [3:0]  memByteEn;
  logic        memAck;
  logic [31:0] memRdata;
  logic        validOut;
  logic        writeEnableOut;
  logic [4:0]  writeBackAddrOut;
  logic [31:0] writeBackData;
  logic        misaligned;
  logic        busError;

  int n_cmp = 0;
  int n_err = 0;
  int stalls;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .inValid          (inValid),
    .aluResult        (aluResult),
    .storeData        (storeData),
    .dataCacheControl (dataCacheControl),
    .writeEnableIn    (writeEnableIn),
    .writeBackAddrIn  (writeBackAddrIn),
    .stall            (stall),
    .memReq           (memReq),
    .memWe            (memWe),
    .memAddr          (memAddr),
    .memWdata         (memWdata),
    .memByteEn        (memByteEn),
    .memAck           (memAck),
    .memRdata         (memRdata),
    .validOut         (validOut),
    .writeEnableOut   (writeEnableOut),
    .writeBackAddrOut (writeBackAddrOut),
    .writeBackData    (writeBackData),
    .misaligned       (misaligned),
    .busError         (busError)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    inValid          = 1'b0;
    dataCacheControl = 4'd0;
    aluResult        = '0;
    storeData        = '0;
    writeEnableIn    = 1'b0;
    writeBackAddrIn  = '0;
    memAck           = 1'b0;
    memRdata         = '0;
  endtask

  task automatic drive(input logic [3:0] ctl, input logic [31:0] addr, input logic [31:0] sd,
                       input logic we, input logic [4:0] rd);
    inValid          = 1'b1;
    dataCacheControl = ctl;
    aluResult        = addr;
    storeData        = sd;
    writeEnableIn    = we;
    writeBackAddrIn  = rd;
  endtask

  // Holds the instruction while stall=1, acks in BUSY cycle ack_after+1 (never if -1),
  // and checks the request fields in every BUSY cycle. Returns one cycle after the last
  // non-stalled cycle, with the completion outputs visible.
  task automatic mem_op(input logic [3:0] ctl, input logic [31:0] addr, input logic [31:0] sd,
                        input logic [4:0] rd, input int ack_after, input logic [31:0] rdata,
                        input logic [31:0] exp_addr, input logic exp_we,
                        input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                        output int n_stall);
    logic done;
    done    = 1'b0;
    n_stall = 0;
    drive(ctl, addr, sd, 1'b1, rd);
    for (int cyc = 0; cyc < 20 && !done; cyc++) begin
      memAck   = (cyc == ack_after + 1);
      memRdata = rdata;
      #1;
      if (cyc == 0) begin
        check("req_before_busy", {31'd0, memReq}, 32'd0);
      end else begin
        check("req_busy",   {31'd0, memReq}, 32'd1);
        check("req_addr",   memAddr, exp_addr);
        check("req_we",     {31'd0, memWe}, {31'd0, exp_we});
        check("req_be",     {28'd0, memByteEn}, {28'd0, exp_be});
        check("req_wdata",  memWdata, exp_wdata);
        check("busy_valid", {31'd0, validOut}, 32'd0);
      end
      if (stall) n_stall++;
      else done = 1'b1;
      tick();
    end
    check("stall_bound", {31'd0, done}, 32'd1);
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    #1;
    check("rst_stall",    {31'd0, stall}, 32'd0);
    check("rst_memreq",   {31'd0, memReq}, 32'd0);
    check("rst_valid",    {31'd0, validOut}, 32'd0);
    check("rst_wbdata",   writeBackData, 32'd0);
    check("rst_memaddr",  memAddr, 32'd0);
    rst = 1'b0;
    tick();

    // Pass-through ALU op.
    drive(4'd0, 32'h0000_1234, 32'd0, 1'b1, 5'd5);
    #1;
    check("pt_stall", {31'd0, stall}, 32'd0);
    tick();
    idle_inputs();
    #1;
    check("pt_valid",  {31'd0, validOut}, 32'd1);
    check("pt_wen",    {31'd0, writeEnableOut}, 32'd1);
    check("pt_wbaddr", {27'd0, writeBackAddrOut}, 32'd5);
    check("pt_wbdata", writeBackData, 32'h0000_1234);
    check("pt_stall2", {31'd0, stall}, 32'd0);
    tick();
    check("bubble_valid", {31'd0, validOut}, 32'd0);

    // LB at 0x1003, ack in 4th BUSY cycle.
    mem_op(4'd1, 32'h0000_1003, 32'd0, 5'd7, 3, 32'h80FF_FF7F,
           32'h0000_1000, 1'b0, 4'b1111, 32'd0, stalls);
    check("lb_stalls", stalls, 32'd4);
    check("lb_valid",  {31'd0, validOut}, 32'd1);
    check("lb_wen",    {31'd0, writeEnableOut}, 32'd1);
    check("lb_wbaddr", {27'd0, writeBackAddrOut}, 32'd7);
    check("lb_data",   writeBackData, 32'hFFFF_FF80);
    check("lb_reqdrop", {31'd0, memReq}, 32'd0);
    tick();

    // LBU, same setup.
    mem_op(4'd4, 32'h0000_1003, 32'd0, 5'd8, 3, 32'h80FF_FF7F,
           32'h0000_1000, 1'b0, 4'b1111, 32'd0, stalls);
    check("lbu_stalls", stalls, 32'd4);
    check("lbu_data",   writeBackData, 32'h0000_0080);
    tick();

    // LH at lane 2: sign-extended upper half.
    mem_op(4'd2, 32'h0000_500A, 32'd0, 5'd9, 1, 32'h8001_1234,
           32'h0000_5008, 1'b0, 4'b1111, 32'd0, stalls);
    check("lh_stalls", stalls, 32'd2);
    check("lh_data",   writeBackData, 32'hFFFF_8001);
    tick();

    // SH at 0x2002, ack in first BUSY cycle.
    mem_op(4'd7, 32'h0000_2002, 32'hAAAA_BEEF, 5'd4, 0, 32'd0,
           32'h0000_2000, 1'b1, 4'b1100, 32'hBEEF_BEEF, stalls);
    check("sh_stalls", stalls, 32'd1);
    check("sh_valid",  {31'd0, validOut}, 32'd1);
    check("sh_wen",    {31'd0, writeEnableOut}, 32'd0);
    tick();

    // SB at lane 1.
    mem_op(4'd6, 32'h0000_6001, 32'h1234_56A5, 5'd4, 0, 32'd0,
           32'h0000_6000, 1'b1, 4'b0010, 32'hA5A5_A5A5, stalls);
    check("sb_stalls", stalls, 32'd1);
    tick();

    // Misaligned LW at 0x3001.
    drive(4'd3, 32'h0000_3001, 32'd0, 1'b1, 5'd6);
    #1;
    check("mis_stall", {31'd0, stall}, 32'd0);
    tick();
    idle_inputs();
    #1;
    check("mis_pulse",  {31'd0, misaligned}, 32'd1);
    check("mis_valid",  {31'd0, validOut}, 32'd1);
    check("mis_wen",    {31'd0, writeEnableOut}, 32'd0);
    check("mis_memreq", {31'd0, memReq}, 32'd0);
    tick();
    check("mis_once",    {31'd0, misaligned}, 32'd0);
    check("mis_memreq2", {31'd0, memReq}, 32'd0);

    // Timeout: no ack, 4 BUSY cycles then abort.
    mem_op(4'd3, 32'h0000_7000, 32'd0, 5'd10, -1, 32'd0,
           32'h0000_7000, 1'b0, 4'b1111, 32'd0, stalls);
    check("to_stalls",  stalls, 32'd4);
    check("to_buserr",  {31'd0, busError}, 32'd1);
    check("to_memreq",  {31'd0, memReq}, 32'd0);
    check("to_valid",   {31'd0, validOut}, 32'd1);
    check("to_wen",     {31'd0, writeEnableOut}, 32'd0);
    drive(4'd0, 32'h0000_0055, 32'd0, 1'b1, 5'd3);
    memAck = 1'b1;
    #1;
    check("late_ack_stall", {31'd0, stall}, 32'd0);
    tick();
    idle_inputs();
    #1;
    check("to_once",      {31'd0, busError}, 32'd0);
    check("late_memreq",  {31'd0, memReq}, 32'd0);
    check("late_valid",   {31'd0, validOut}, 32'd1);
    check("late_wen",     {31'd0, writeEnableOut}, 32'd1);
    check("late_wbaddr",  {27'd0, writeBackAddrOut}, 32'd3);
    check("late_wbdata",  writeBackData, 32'h0000_0055);
    tick();

    // Reset asserted in the 2nd BUSY cycle, then a stale ack.
    drive(4'd3, 32'h0000_4000, 32'd0, 1'b1, 5'd11);
    #1;
    check("rm_stall0", {31'd0, stall}, 32'd1);
    tick();
    check("rm_req1", {31'd0, memReq}, 32'd1);
    tick();
    rst = 1'b1;
    #1;
    check("rm_stall_rst", {31'd0, stall}, 32'd0);
    tick();
    rst = 1'b0;
    idle_inputs();
    memAck   = 1'b1;
    memRdata = 32'hDEAD_BEEF;
    #1;
    check("rm_memreq",  {31'd0, memReq}, 32'd0);
    check("rm_memaddr", memAddr, 32'd0);
    check("rm_be",      {28'd0, memByteEn}, 32'd0);
    check("rm_valid",   {31'd0, validOut}, 32'd0);
    check("rm_wbdata",  writeBackData, 32'd0);
    check("rm_stall",   {31'd0, stall}, 32'd0);
    tick();
    memAck = 1'b0;
    check("rm_ack_ign_valid", {31'd0, validOut}, 32'd0);
    check("rm_ack_ign_data",  writeBackData, 32'd0);
    drive(4'd0, 32'h0000_0077, 32'd0, 1'b1, 5'd2);
    #1;
    check("rm_add_stall", {31'd0, stall}, 32'd0);
    tick();
    idle_inputs();
    #1;
    check("rm_add_valid", {31'd0, validOut}, 32'd1);
    check("rm_add_data",  writeBackData, 32'h0000_0077);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage consumer of the ALU stage's outputs: the receiving end of the data-cache-control, write-back-address and write-enable bundle that travels down the pipeline.
- Executes loads and stores against a req/ack data-memory port and stalls upstream while a transaction is in flight.
- Aligns and extends load data, then registers the write-back bundle for the WB stage.
- Non-memory ops pass through as an ordinary pipeline register.

Parameters:
TIMEOUT_CYCLES, 255, max BUSY cycles awaiting memAck before abort; 0 disables the timeout.

Ports:
clk  input  1  clock
rst  input  1  reset
inValid  input  1  upstream slot holds a real instruction
aluResult  input  32  ALU result; byte address for load/store
storeData  input  32  rs2 value for stores
dataCacheControl  input  4  op: 0 NONE, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW; other codes treated as NONE
writeEnableIn  input  1  instruction writes rd
writeBackAddrIn  input  5  rd
stall  output  1  hold upstream stage registers (combinational)
memReq  output  1  request valid, held until ack
memWe  output  1  1 = store
memAddr  output  32  word-aligned address ({addr[31:2],2'b00})
memWdata  output  32  lane-replicated store data
memByteEn  output  4  byte enables
memAck  input  1  one-cycle completion; memRdata valid in the same cycle
memRdata  input  32  read word
validOut  output  1  WB slot valid
writeEnableOut  output  1  write rd
writeBackAddrOut  output  5  rd
writeBackData  output  32  ALU result or load data
misaligned  output  1  one-cycle pulse: misaligned access dropped
busError  output  1  one-cycle pulse: timeout abort

Behaviour:
- Reset: synchronous, active-high. rst=1 at a clk edge forces state IDLE, clears the timeout counter, and zeroes every registered output (memReq, memWe, memAddr, memWdata, memByteEn, validOut, writeEnableOut, writeBackAddrOut, writeBackData, misaligned, busError). While rst=1, stall=0.
- FSM states: IDLE, BUSY.
- IDLE, non-memory op or bubble: outputs registered next cycle. validOut=inValid; writeEnableOut=inValid&writeEnableIn; writeBackData=aluResult. Latency 1, stall=0.
- IDLE, aligned memory op with inValid=1: stall=1 this cycle. Latch op, addr[1:0] and rd; drive memReq/memWe/memAddr/memWdata/memByteEn from the next cycle; go to BUSY. validOut=0 this cycle.
- Alignment rules: LH/LHU/SH require addr[0]=0. LW/SW require addr[1:0]=0. Byte ops always aligned.
- Misaligned op: no request, stall=0. Next cycle: misaligned=1, validOut=1, writeEnableOut=0.
- BUSY: stall=!memAck.
- memAck in BUSY: next edge goes to IDLE and drops memReq. Next cycle: validOut=1. Loads: writeEnableOut=latched write enable, writeBackData=aligned load data. Stores: writeEnableOut=0.
- Minimum memory-op stall: 1 cycle (ack in the first BUSY cycle).
- Timeout: counter increments each BUSY cycle without ack. On reaching TIMEOUT_CYCLES: go to IDLE, drop memReq, pulse busError, validOut=1, writeEnableOut=0, stall=0 in that cycle.
- memAck while IDLE: ignored. This includes a late ack after a timeout or a reset mid-transaction.
- Load extraction (lane = addr[1:0]):
  - LB: sign-extend byte[lane]. LBU: zero-extend byte[lane].
  - LH: sign-extend half[addr[1]]. LHU: zero-extend half[addr[1]].
  - LW: full word.
- Store data and enables:
  - SB: memWdata={4{sd[7:0]}}, memByteEn=4'b0001<<lane.
  - SH: memWdata={2{sd[15:0]}}, memByteEn=4'b0011<<lane.
  - SW: memWdata=sd, memByteEn=4'b1111.
  - Loads: memByteEn=4'b1111.
- Request outputs stay stable from memReq rise until the ack cycle inclusive.

Decomposition:
- define.v: op encodings MEM_NONE..MEM_SW, `DataCacheControlBus [3:0], `DataSize, `RegAddrSize, state encodings.
- Sub-module mem_load_align: combinational; inputs op, lane, memRdata; output 32-bit extended data.

Test Plan:
- Pipeline pass-through: add result 0x0000_1234 to rd 5 → next cycle validOut=1, writeEnableOut=1, writeBackAddrOut=5, writeBackData=0x1234, stall=0 throughout.
- LB at 0x1003, memAck after 3 BUSY cycles with memRdata=0x80FF_FF7F → memAddr=0x1000, stall=1 for 4 cycles, writeBackData=0xFFFF_FF80. LBU on the same setup → 0x0000_0080.
- SH at 0x2002, storeData=0xAAAA_BEEF, ack in the first BUSY cycle → memWe=1, memByteEn=4'b1100, memWdata=0xBEEF_BEEF, writeEnableOut=0, exactly 1 stall cycle.
- LW at 0x3001 → memReq stays 0, misaligned pulses once, writeEnableOut=0, stall=0.
- TIMEOUT_CYCLES=4, no ack → memReq drops after 4 BUSY cycles, busError pulses once; a late memAck is ignored and the next add passes normally.
- rst asserted in the 2nd BUSY cycle → next cycle memReq=0, all outputs 0, state IDLE; a stale memAck has no effect.
